hazard_scoreboard: RTL and testbench

Parametrised hazard-control unit for the five-stage core. It extends load-use and WB-to-decode stalling, EX-stage forwarding select and branch/jump flushing with three additions: a per-register scoreboard for variable-latency (multi-cycle) operations, a selectable WB-to-decode bypass mode, and saturating stall/flush performance counters. It sits beside the pipeline registers and drives their write-enable, flush and forwarding-mux controls.

---
 rtl/hazard_scoreboard.sv | 129 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline hazard control for the five-stage core.
// Detects load-use, WB-to-decode and scoreboard (multi-cycle RAW/WAW) hazards,
// selects EX forwarding sources, flushes on control-flow change, and keeps
// saturating stall/flush performance counters.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned RA_W      = 5,
  parameter int unsigned LAT_W     = 4,
  parameter int unsigned CNT_W     = 32,
  parameter bit          WD_BYPASS = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                d_valid,
  input  logic [RA_W-1:0]     d_rs1,
  input  logic [RA_W-1:0]     d_rs2,
  input  logic [RA_W-1:0]     d_rd,
  input  logic                d_uses_rs1,
  input  logic                d_uses_rs2,
  input  logic                d_regwren,
  input  logic [LAT_W-1:0]    d_lat,
  input  logic [RA_W-1:0]     e_rs1,
  input  logic [RA_W-1:0]     e_rs2,
  input  logic [RA_W-1:0]     e_rd,
  input  logic                e_memren,
  input  logic                e_br_taken,
  input  logic                e_jump,
  input  logic [RA_W-1:0]     m_rd,
  input  logic [RA_W-1:0]     w_rd,
  input  logic                m_regwren,
  input  logic                w_regwren,
  input  logic                cnt_clr,
  output logic                stall_if,
  output logic                ifid_wren,
  output logic                ifid_flush,
  output logic                idex_flush,
  output logic [1:0]          rs1_sel,
  output logic [1:0]          rs2_sel,
  output logic [NUM_REGS-1:0] sb_busy,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  logic [LAT_W-1:0]    r_sb_cnt [1:NUM_REGS-1];
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic [NUM_REGS-1:0] w_busy;
  logic                w_cfc;
  logic                w_lu;
  logic                w_wd;
  logic                w_sb;
  logic                w_hz;
  logic                w_issue;
  logic                w_set;

  // Busy vector from the per-register latency counters; x0 is never busy.
  always_comb begin
    w_busy = '0;
    for (int r = 1; r < int'(NUM_REGS); r++) begin
      w_busy[r] = (r_sb_cnt[r] != '0);
    end
  end

  // Hazard terms and stall/flush decisions; control-flow change wins over stalls.
  always_comb begin
    w_cfc = e_br_taken | e_jump;
    w_lu  = e_memren && (e_rd != '0) &&
            ((e_rd == d_rs1 && d_uses_rs1) || (e_rd == d_rs2 && d_uses_rs2));
    w_wd  = !WD_BYPASS && w_regwren && (w_rd != '0) &&
            ((w_rd == d_rs1 && d_uses_rs1) || (w_rd == d_rs2 && d_uses_rs2));
    w_sb  = (w_busy[d_rs1] && d_uses_rs1) || (w_busy[d_rs2] && d_uses_rs2) ||
            (w_busy[d_rd] && d_regwren);
    w_hz    = d_valid && (w_lu || w_wd || w_sb);
    w_issue = d_valid && !w_hz && !w_cfc;
    w_set   = w_issue && d_regwren && (d_rd != '0) && (d_lat >= LAT_W'(2));
  end

  // EX operand forwarding: MEM has priority over WB, x0 never forwards.
  always_comb begin
    rs1_sel = SEL_RF;
    rs2_sel = SEL_RF;
    if (m_regwren && (m_rd != '0) && (m_rd == e_rs1))      rs1_sel = SEL_MEM;
    else if (w_regwren && (w_rd != '0) && (w_rd == e_rs1)) rs1_sel = SEL_WB;
    if (m_regwren && (m_rd != '0) && (m_rd == e_rs2))      rs2_sel = SEL_MEM;
    else if (w_regwren && (w_rd != '0) && (w_rd == e_rs2)) rs2_sel = SEL_WB;
  end

  assign stall_if   = w_hz && !w_cfc;
  assign ifid_wren  = !(w_hz && !w_cfc);
  assign ifid_flush = w_cfc;
  assign idex_flush = w_cfc || w_hz;
  assign sb_busy    = w_busy;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

  // Scoreboard counters: load on multi-cycle issue, otherwise count down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 1; r < int'(NUM_REGS); r++) r_sb_cnt[r] <= '0;
    end else begin
      for (int r = 1; r < int'(NUM_REGS); r++) begin
        if (w_set && (d_rd == RA_W'(r))) r_sb_cnt[r] <= d_lat - LAT_W'(1);
        else if (r_sb_cnt[r] != '0)      r_sb_cnt[r] <= r_sb_cnt[r] - LAT_W'(1);
      end
    end
  end

  // Saturating stall/flush performance counters; clear beats increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_if && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (ifid_flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default instance (stalling WB-to-decode,
// 32-bit counters) and a bypass instance with 4-bit counters share all inputs.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid, d_uses_rs1, d_uses_rs2, d_regwren;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [3:0]  d_lat;
  logic [4:0]  e_rs1, e_rs2, e_rd, m_rd, w_rd;
  logic        e_memren, e_br_taken, e_jump, m_regwren, w_regwren, cnt_clr;

  logic        a_stall_if, a_ifid_wren, a_ifid_flush, a_idex_flush;
  logic [1:0]  a_rs1_sel, a_rs2_sel;
  logic [31:0] a_sb_busy, a_stall_cnt, a_flush_cnt;

  logic        b_stall_if, b_ifid_wren, b_ifid_flush, b_idex_flush;
  logic [1:0]  b_rs1_sel, b_rs2_sel;
  logic [31:0] b_sb_busy;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard u_dut_a (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rd(d_rd), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .d_regwren(d_regwren), .d_lat(d_lat), .e_rs1(e_rs1), .e_rs2(e_rs2),
    .e_rd(e_rd), .e_memren(e_memren), .e_br_taken(e_br_taken), .e_jump(e_jump),
    .m_rd(m_rd), .w_rd(w_rd), .m_regwren(m_regwren), .w_regwren(w_regwren),
    .cnt_clr(cnt_clr), .stall_if(a_stall_if), .ifid_wren(a_ifid_wren),
    .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .rs1_sel(a_rs1_sel),
    .rs2_sel(a_rs2_sel), .sb_busy(a_sb_busy), .stall_cnt(a_stall_cnt),
    .flush_cnt(a_flush_cnt)
  );

  hazard_scoreboard #(.CNT_W(4), .WD_BYPASS(1'b1)) u_dut_b (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs2(d_rs2),
    .d_rd(d_rd), .d_uses_rs1(d_uses_rs1), .d_uses_rs2(d_uses_rs2),
    .d_regwren(d_regwren), .d_lat(d_lat), .e_rs1(e_rs1), .e_rs2(e_rs2),
    .e_rd(e_rd), .e_memren(e_memren), .e_br_taken(e_br_taken), .e_jump(e_jump),
    .m_rd(m_rd), .w_rd(w_rd), .m_regwren(m_regwren), .w_regwren(w_regwren),
    .cnt_clr(cnt_clr), .stall_if(b_stall_if), .ifid_wren(b_ifid_wren),
    .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .rs1_sel(b_rs1_sel),
    .rs2_sel(b_rs2_sel), .sb_busy(b_sb_busy), .stall_cnt(b_stall_cnt),
    .flush_cnt(b_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 2-3 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    d_valid = 0; d_uses_rs1 = 0; d_uses_rs2 = 0; d_regwren = 0;
    d_rs1 = 0; d_rs2 = 0; d_rd = 0; d_lat = 0;
    e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_memren = 0; e_br_taken = 0; e_jump = 0;
    m_rd = 0; w_rd = 0; m_regwren = 0; w_regwren = 0; cnt_clr = 0;
  endtask

  task automatic issue_mc(input logic [4:0] rd, input logic [3:0] lat);
    idle();
    d_valid = 1; d_regwren = 1; d_rd = rd; d_lat = lat;
    tick();
    idle();
  endtask

  task automatic clear_cnts();
    idle();
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
  endtask

  // Count stall cycles of the current decode, bounded to 20 cycles.
  task automatic count_stalls(output int stalls, output int busy_cycles, input int reg_idx);
    stalls = 0;
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (a_sb_busy[reg_idx]) busy_cycles++;
      if (!a_stall_if) break;
      stalls++;
      tick();
    end
  endtask

  int ns, nb;

  initial begin
    idle();
    reset = 1;
    #1;
    check("rst_busy", a_sb_busy, 32'h0);
    check("rst_stall_cnt", a_stall_cnt, 32'd0);
    check("rst_flush_cnt", a_flush_cnt, 32'd0);
    check("rst_stall_if", 32'(a_stall_if), 32'd0);
    check("rst_ifid_wren", 32'(a_ifid_wren), 32'd1);
    check("rst_flushes", {30'd0, a_ifid_flush, a_idex_flush}, 32'd0);
    check("rst_sels", {28'd0, a_rs1_sel, a_rs2_sel}, 32'd0);
    tick(); tick();
    reset = 0;
    tick();

    // Load-use on rs1
    e_memren = 1; e_rd = 5; d_valid = 1; d_rs1 = 5; d_uses_rs1 = 1;
    #1;
    check("lu_stall_if", 32'(a_stall_if), 32'd1);
    check("lu_ifid_wren", 32'(a_ifid_wren), 32'd0);
    check("lu_idex_flush", 32'(a_idex_flush), 32'd1);
    check("lu_ifid_flush", 32'(a_ifid_flush), 32'd0);
    tick();
    idle();
    #1;
    check("lu_stall_cnt", a_stall_cnt, 32'd1);
    check("lu_flush_cnt", a_flush_cnt, 32'd0);

    // Multi-cycle RAW: rd=7 lat=4, consumer reads rs2=7
    clear_cnts();
    #1;
    check("clr_stall_cnt", a_stall_cnt, 32'd0);
    issue_mc(5'd7, 4'd4);
    d_valid = 1; d_rs2 = 7; d_uses_rs2 = 1;
    count_stalls(ns, nb, 7);
    check("raw_stalls", 32'(ns), 32'd3);
    check("raw_busy_cycles", 32'(nb), 32'd3);
    check("raw_stall_cnt", a_stall_cnt, 32'd3);
    check("raw_busy_clear", a_sb_busy, 32'h0);
    idle();

    // x0 destination never becomes busy
    clear_cnts();
    d_valid = 1; d_regwren = 1; d_rd = 0; d_lat = 6;
    #1;
    check("x0_no_stall", 32'(a_stall_if), 32'd0);
    tick();
    idle();
    #1;
    check("x0_busy", a_sb_busy, 32'h0);

    // WAW: rd=9 lat=3, then ordinary write to rd=9
    issue_mc(5'd9, 4'd3);
    #1;
    check("waw_busy9", a_sb_busy, 32'h0000_0200);
    d_valid = 1; d_regwren = 1; d_rd = 9; d_lat = 0;
    count_stalls(ns, nb, 9);
    check("waw_stalls", 32'(ns), 32'd2);
    tick();
    idle();
    #1;
    check("waw_no_new_entry", a_sb_busy, 32'h0);

    // Branch during a scoreboard stall
    clear_cnts();
    issue_mc(5'd3, 4'd3);
    d_valid = 1; d_rs1 = 3; d_uses_rs1 = 1; d_regwren = 1; d_rd = 12; d_lat = 5;
    e_br_taken = 1;
    #1;
    check("br_busy3", 32'(a_sb_busy[3]), 32'd1);
    check("br_stall_if", 32'(a_stall_if), 32'd0);
    check("br_ifid_wren", 32'(a_ifid_wren), 32'd1);
    check("br_ifid_flush", 32'(a_ifid_flush), 32'd1);
    check("br_idex_flush", 32'(a_idex_flush), 32'd1);
    tick();
    idle();
    #1;
    check("br_flush_cnt", a_flush_cnt, 32'd1);
    check("br_stall_cnt", a_stall_cnt, 32'd0);
    check("br_no_entry12", 32'(a_sb_busy[12]), 32'd0);
    e_jump = 1;
    #1;
    check("jmp_ifid_flush", 32'(a_ifid_flush), 32'd1);
    tick();
    idle();
    #1;
    check("jmp_flush_cnt", a_flush_cnt, 32'd2);
    tick(); tick();

    // Forwarding priority and x0
    m_rd = 4; w_rd = 4; e_rs1 = 4; m_regwren = 1; w_regwren = 1;
    #1;
    check("fwd_mem", {30'd0, a_rs1_sel}, 32'd1);
    check("fwd_rs2_rf", {30'd0, a_rs2_sel}, 32'd0);
    m_regwren = 0; e_rs2 = 4;
    #1;
    check("fwd_wb_rs1", {30'd0, a_rs1_sel}, 32'd2);
    check("fwd_wb_rs2", {30'd0, a_rs2_sel}, 32'd2);
    m_regwren = 1; m_rd = 0; w_rd = 0; e_rs1 = 0; e_rs2 = 0;
    #1;
    check("fwd_x0", {28'd0, a_rs1_sel, a_rs2_sel}, 32'd0);

    // WB-to-decode: stalls without bypass, not with bypass
    idle();
    w_regwren = 1; w_rd = 4; d_valid = 1; d_rs2 = 4; d_uses_rs2 = 1;
    #1;
    check("wd_stall_nobypass", 32'(a_stall_if), 32'd1);
    check("wd_stall_bypass", 32'(b_stall_if), 32'd0);
    idle();

    // Saturation and clear priority
    clear_cnts();
    e_memren = 1; e_rd = 5; d_valid = 1; d_rs1 = 5; d_uses_rs1 = 1;
    for (int i = 0; i < 20; i++) tick();
    #1;
    check("sat_cnt4", {28'd0, b_stall_cnt}, 32'd15);
    check("sat_cnt32", a_stall_cnt, 32'd20);
    cnt_clr = 1;
    tick();
    #1;
    check("clr_prio_a", a_stall_cnt, 32'd0);
    check("clr_prio_b", {28'd0, b_stall_cnt}, 32'd0);
    idle();

    // Reset mid-operation clears the scoreboard immediately
    issue_mc(5'd7, 4'd8);
    #1;
    check("mid_busy7", 32'(a_sb_busy[7]), 32'd1);
    reset = 1;
    #1;
    check("mid_rst_busy", a_sb_busy, 32'h0);
    tick();
    reset = 0;
    tick();
    #1;
    check("post_rst_busy", a_sb_busy, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
